// File: rtl/ptp_ts_pkg.sv
// Shared widths, the packed timestamp record and the latency-compensation helper
// used by the PTP timestamp capture block.
package ptp_ts_pkg;

  localparam int unsigned SEC_W = 48;
  localparam int unsigned NS_W  = 32;
  localparam int unsigned TAG_W = 8;

  localparam logic [NS_W-1:0] NS_PER_SEC = 32'd1_000_000_000;

  typedef struct packed {
    logic [SEC_W-1:0] sec;
    logic [NS_W-1:0]  ns;
    logic [TAG_W-1:0] tag;
  } ts_rec_t;

  localparam int unsigned TS_REC_W = $bits(ts_rec_t);

  // Both operands are below one second, so the sum needs one spare bit and at most one carry.
  function automatic ts_rec_t ts_add_latency(input ts_rec_t rec, input logic [NS_W-1:0] lat_ns);
    ts_rec_t       result;
    logic [NS_W:0] sum;
    result = rec;
    sum    = {1'b0, rec.ns} + {1'b0, lat_ns};
    if (sum >= {1'b0, NS_PER_SEC}) begin
      result.ns  = NS_W'(sum - {1'b0, NS_PER_SEC});
      result.sec = rec.sec + SEC_W'(1);
    end else begin
      result.ns  = sum[NS_W-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/ptp_ts_fifo.sv
// Synchronous first-word-fall-through FIFO; a write arriving while full is dropped
// unless the head is popped in the same cycle.
module ptp_ts_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wrEn,
  input  logic [WIDTH-1:0]       i_wrData,
  input  logic                   i_rdEn,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_rdData,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = i_rdEn & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign w_push  = i_wrEn & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign o_rdData = w_empty ? '0 : r_mem[r_rdPtr];
  assign o_valid  = ~w_empty;
  assign o_count  = r_count;
  assign o_drop   = i_wrEn & w_full & ~w_pop;

endmodule

// File: rtl/ptp_ts_capture.sv
// Captures PTP time on start-of-frame strobes into a two-stage pipeline feeding a FWFT FIFO.
// Defining PTP_TS_LATCOMP_EN adds LAT_NS (with second carry) to every capture.
module ptp_ts_capture
  import ptp_ts_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LAT_NS     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEC_W-1:0]            time_ptp_sec,
  input  logic [NS_W-1:0]             time_ptp_ns,
  input  logic                        sof_strb,
  input  logic [TAG_W-1:0]            sof_tag,
  output logic                        ts_valid,
  input  logic                        ts_ready,
  output logic [SEC_W-1:0]            ts_sec,
  output logic [NS_W-1:0]             ts_ns,
  output logic [TAG_W-1:0]            ts_tag,
  output logic [$clog2(FIFO_DEPTH):0] ts_count,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  if ((FIFO_DEPTH < 4) || (FIFO_DEPTH > 64) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
      (LAT_NS >= NS_PER_SEC)) begin : g_badParams
    $error("ptp_ts_capture: FIFO_DEPTH must be a power of two in 4..64 and LAT_NS below 10^9");
  end

  logic    r_armed;
  logic    r_s1Valid;
  ts_rec_t r_s1Rec;
  logic    r_overflow;

  logic    w_capture;
  ts_rec_t w_s2Rec;
  ts_rec_t w_head;
  logic    w_drop;

  // r_armed stays low for the first edge after reset release so a strobe racing
  // the deassertion is not captured with half-initialised pipeline state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  assign w_capture = sof_strb & r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Rec   <= '0;
    end else begin
      r_s1Valid <= w_capture;
      if (w_capture) begin
        r_s1Rec <= '{sec: time_ptp_sec, ns: time_ptp_ns, tag: sof_tag};
      end
    end
  end

`ifdef PTP_TS_LATCOMP_EN
  assign w_s2Rec = ts_add_latency(r_s1Rec, NS_W'(LAT_NS));
`else
  assign w_s2Rec = r_s1Rec;
`endif

  ptp_ts_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TS_REC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wrEn   (r_s1Valid),
    .i_wrData (w_s2Rec),
    .i_rdEn   (ts_ready),
    .o_valid  (ts_valid),
    .o_rdData (w_head),
    .o_count  (ts_count),
    .o_drop   (w_drop)
  );

  // A drop in the same cycle as a clear wins, so no overflow event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
  assign ts_sec   = w_head.sec;
  assign ts_ns    = w_head.ns;
  assign ts_tag   = w_head.tag;

endmodule

// File: tb/tb_ptp_ts_capture.sv
// Directed self-checking bench for ptp_ts_capture: one instance with LAT_NS=0 and one with
// LAT_NS=16 whose expected values follow PTP_TS_LATCOMP_EN.
module tb_ptp_ts_capture;
  import ptp_ts_pkg::*;

  localparam int unsigned DEPTH = 16;

`ifdef PTP_TS_LATCOMP_EN
  localparam logic [47:0] EXP_WRAP_SEC = 48'h0;
  localparam logic [31:0] EXP_WRAP_NS  = 32'd6;
  localparam logic [47:0] EXP_POST_SEC = 48'h124;
  localparam logic [31:0] EXP_POST_NS  = 32'd15;
`else
  localparam logic [47:0] EXP_WRAP_SEC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] EXP_WRAP_NS  = 32'd999_999_990;
  localparam logic [47:0] EXP_POST_SEC = 48'h123;
  localparam logic [31:0] EXP_POST_NS  = 32'd999_999_999;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] timePtpSec;
  logic [31:0] timePtpNs;
  logic        sofStrb;
  logic [7:0]  sofTag;
  logic        tsReady;
  logic        ovfClr;

  logic        tsValid,    tsValidL;
  logic [47:0] tsSec,      tsSecL;
  logic [31:0] tsNs,       tsNsL;
  logic [7:0]  tsTag,      tsTagL;
  logic [4:0]  tsCount,    tsCountL;
  logic        overflow,   overflowL;

  int nChecks = 0;
  int nPassed = 0;

  // Free-running 100 MHz clock shared by both instances.
  always #5 clk = ~clk;

  ptp_ts_capture #(.FIFO_DEPTH(DEPTH), .LAT_NS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .time_ptp_sec(timePtpSec), .time_ptp_ns(timePtpNs),
    .sof_strb(sofStrb), .sof_tag(sofTag), .ts_valid(tsValid), .ts_ready(tsReady),
    .ts_sec(tsSec), .ts_ns(tsNs), .ts_tag(tsTag), .ts_count(tsCount),
    .overflow(overflow), .ovf_clr(ovfClr)
  );

  ptp_ts_capture #(.FIFO_DEPTH(DEPTH), .LAT_NS(16)) u_dutLat (
    .clk(clk), .rst_n(rst_n), .time_ptp_sec(timePtpSec), .time_ptp_ns(timePtpNs),
    .sof_strb(sofStrb), .sof_tag(sofTag), .ts_valid(tsValidL), .ts_ready(tsReady),
    .ts_sec(tsSecL), .ts_ns(tsNsL), .ts_tag(tsTagL), .ts_count(tsCountL),
    .overflow(overflowL), .ovf_clr(ovfClr)
  );

  // Advance to just after the next rising edge, where inputs change and outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic strb, input logic [47:0] sec,
                               input logic [31:0] ns, input logic [7:0] tag);
    sofStrb    = strb;
    timePtpSec = sec;
    timePtpNs  = ns;
    sofTag     = tag;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) nPassed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: reset, latency/carry, FWFT handoff, overflow, full streaming, reset flush.
  initial begin
    logic [7:0] expTag;
    applyStimulus(1'b0, '0, '0, '0);
    tsReady = 1'b0;
    ovfClr  = 1'b0;
    rst_n   = 1'b0;
    repeat (2) tick();
    checkOutput("rst_valid", tsValid, 0);
    checkOutput("rst_count", tsCount, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_sec", tsSec, 0);
    checkOutput("rst_tag", tsTag, 0);

    // Strobe coincident with reset release must be ignored.
    rst_n = 1'b1;
    applyStimulus(1'b1, 48'd9, 32'd9, 8'd9);
    tick();
    sofStrb = 1'b0;
    repeat (3) tick();
    checkOutput("first_strobe_ignored_count", tsCount, 0);
    checkOutput("first_strobe_ignored_valid", tsValid, 0);

    // Seconds wrap and nanosecond carry on the LAT_NS=16 instance.
    applyStimulus(1'b1, 48'hFFFF_FFFF_FFFF, 32'd999_999_990, 8'h7E);
    tick();
    sofStrb = 1'b0;
    checkOutput("wrap_n1_valid", tsValid, 0);
    tick();
    checkOutput("wrap_n2_valid", tsValid, 1);
    checkOutput("nolat_sec", tsSec, 48'hFFFF_FFFF_FFFF);
    checkOutput("nolat_ns", tsNs, 999_999_990);
    checkOutput("lat_valid", tsValidL, 1);
    checkOutput("lat_sec", tsSecL, EXP_WRAP_SEC);
    checkOutput("lat_ns", tsNsL, EXP_WRAP_NS);
    checkOutput("lat_tag", tsTagL, 8'h7E);
    tsReady = 1'b1;
    tick();
    tsReady = 1'b0;
    checkOutput("pop_count", tsCount, 0);
    checkOutput("pop_valid", tsValid, 0);

    // Single capture with two-cycle latency.
    applyStimulus(1'b1, 48'd5, 32'd100, 8'd3);
    tick();
    sofStrb = 1'b0;
    checkOutput("single_n1_valid", tsValid, 0);
    tick();
    checkOutput("single_n2_valid", tsValid, 1);
    checkOutput("single_sec", tsSec, 5);
    checkOutput("single_ns", tsNs, 100);
    checkOutput("single_tag", tsTag, 3);
    checkOutput("single_count", tsCount, 1);

    // Write and pop together at count=1: new entry becomes head, valid stays high.
    applyStimulus(1'b1, 48'd6, 32'd200, 8'd4);
    tick();
    sofStrb = 1'b0;
    checkOutput("handoff_old_head", tsTag, 3);
    tsReady = 1'b1;
    tick();
    tsReady = 1'b0;
    checkOutput("handoff_valid", tsValid, 1);
    checkOutput("handoff_count", tsCount, 1);
    checkOutput("handoff_tag", tsTag, 4);
    checkOutput("handoff_ns", tsNs, 200);
    tick();
    checkOutput("stall_stable_tag", tsTag, 4);
    tsReady = 1'b1;
    tick();
    tsReady = 1'b0;
    checkOutput("handoff_drained", tsCount, 0);

    // 20 back-to-back strobes into a 16-deep FIFO with no consumer.
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 48'(i), 32'(1000 + i), 8'(i));
      tick();
      if (i == 17) begin
        checkOutput("exactly_full_count", tsCount, 16);
        checkOutput("exactly_full_no_ovf", overflow, 0);
      end
    end
    sofStrb = 1'b0;
    tick();
    checkOutput("burst_count", tsCount, 16);
    checkOutput("burst_overflow", overflow, 1);
    checkOutput("burst_head_tag", tsTag, 1);
    checkOutput("burst_head_ns", tsNs, 1001);
    checkOutput("burst_overflow_lat", overflowL, 1);

    // Clear coinciding with a fresh drop keeps the flag; a lone clear drops it.
    applyStimulus(1'b1, 48'd0, 32'd0, 8'hAA);
    tick();
    sofStrb = 1'b0;
    ovfClr  = 1'b1;
    tick();
    ovfClr  = 1'b0;
    checkOutput("clr_vs_drop_overflow", overflow, 1);
    checkOutput("clr_vs_drop_count", tsCount, 16);
    ovfClr = 1'b1;
    tick();
    ovfClr = 1'b0;
    checkOutput("clr_overflow", overflow, 0);

    // Full FIFO with simultaneous push and pop every cycle.
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, 48'(21 + j), 32'(1021 + j), 8'(21 + j));
      tsReady = (j > 0);
      tick();
      if (j > 0) begin
        checkOutput("stream_count", tsCount, 16);
        checkOutput("stream_overflow", overflow, 0);
      end
    end
    sofStrb = 1'b0;
    tsReady = 1'b1;
    tick();
    tsReady = 1'b0;
    checkOutput("stream_end_count", tsCount, 16);
    checkOutput("stream_end_overflow", overflow, 0);
    for (int k = 0; k < 16; k++) begin
      expTag = (k < 8) ? 8'(9 + k) : 8'(21 + k - 8);
      checkOutput("drain_tag", tsTag, expTag);
      checkOutput("drain_ns", tsNs, 1000 + expTag);
      tsReady = 1'b1;
      tick();
      tsReady = 1'b0;
    end
    checkOutput("drain_empty", tsCount, 0);

    // Five entries queued plus one in flight, then asynchronous reset.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 48'(100 + i), 32'(i), 8'(8'h31 + i));
      tick();
    end
    sofStrb = 1'b0;
    checkOutput("prereset_count", tsCount, 5);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", tsValid, 0);
    checkOutput("async_rst_count", tsCount, 0);
    checkOutput("async_rst_sec", tsSec, 0);
    checkOutput("async_rst_ns", tsNs, 0);
    checkOutput("async_rst_tag", tsTag, 0);
    checkOutput("async_rst_count_lat", tsCountL, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checkOutput("post_rst_valid", tsValid, 0);
    checkOutput("post_rst_count", tsCount, 0);

    // Normal capture resumes after reset.
    applyStimulus(1'b1, 48'h123, 32'd999_999_999, 8'h55);
    tick();
    sofStrb = 1'b0;
    tick();
    checkOutput("resume_valid", tsValid, 1);
    checkOutput("resume_sec", tsSec, 48'h123);
    checkOutput("resume_ns", tsNs, 999_999_999);
    checkOutput("resume_tag", tsTag, 8'h55);
    checkOutput("resume_lat_sec", tsSecL, EXP_POST_SEC);
    checkOutput("resume_lat_ns", tsNsL, EXP_POST_NS);

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/ptp_ts_capture.md
PTP_TS_CAPTURE -- requirements
Module: ptp_ts_capture

Interface
REQ-001 SHALL use one clock and one reset: reset is asynchronous and active-low.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning timestamp FIFO entries (power of two, 4..64).
REQ-003 SHALL have parameter LAT_NS, default 0, meaning fixed ingress latency in ns added to each capture (0 <= LAT_NS < 10^9).
REQ-004 SHALL have port clk  in  1  system clock, same domain as the rtc outputs.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port time_ptp_sec  in  48  rtc PTP seconds.
REQ-007 SHALL have port time_ptp_ns  in  32  rtc PTP nanoseconds, always < 10^9.
REQ-008 SHALL have port sof_strb  in  1  single-cycle capture event (frame start-of-frame).
REQ-009 SHALL have port sof_tag  in  8  event tag (port/queue id), sampled with sof_strb.
REQ-010 SHALL have port ts_valid  out  1  FIFO head valid.
REQ-011 SHALL have port ts_ready  in  1  consumer accepts the head.
REQ-012 SHALL have ports ts_sec  out  48, ts_ns  out  32 and ts_tag  out  8, carrying the FIFO head timestamp and tag.
REQ-013 SHALL have port ts_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 SHALL have port overflow  out  1  sticky drop flag.
REQ-015 SHALL have port ovf_clr  in  1  clears overflow.

Function
REQ-016 SHALL, in cycle N where sof_strb=1, register time_ptp_sec, time_ptp_ns and sof_tag into stage S1.
REQ-017 SHALL, in cycle N+1 (stage S2), compute ns' = ns + LAT_NS; when ns' >= 10^9, it SHALL use ns' - 10^9 and sec + 1, with sec wrapping modulo 2^48 (0xFFFF_FFFF_FFFF -> 0).
REQ-018 SHALL write the S2 result into the FIFO at the end of cycle N+1, so ts_valid rises in cycle N+2 when the FIFO was empty.
REQ-019 SHALL accept sof_strb on every cycle, including back-to-back cycles, with no loss while the FIFO is not full.
REQ-020 SHALL make the FIFO first-word-fall-through: ts_valid=1 iff ts_count>0, and ts_sec/ts_ns/ts_tag SHALL always show the oldest entry.
REQ-021 SHALL pop the head when ts_valid & ts_ready are both high at a rising edge; when ts_valid=0, ts_ready SHALL be ignored.
REQ-022 SHALL evaluate full at the write cycle: a write with count=FIFO_DEPTH and no pop that cycle SHALL be dropped and SHALL set overflow.
REQ-023 SHALL accept a simultaneous write and pop when full, leaving count unchanged.
REQ-024 SHALL, on a simultaneous write and pop when count=1, present the new entry as head in the next cycle with ts_valid held at 1.
REQ-025 SHALL keep overflow set until ovf_clr=1; when ovf_clr and a new drop coincide, overflow SHALL stay 1.
REQ-026 SHALL keep ts_sec/ts_ns/ts_tag stable while ts_valid=1 and ts_ready=0.

Reset
REQ-027 SHALL, on rst_n=0, clear the S1/S2 valid bits, FIFO pointers, ts_count, ts_valid, ts_sec, ts_ns, ts_tag and overflow to 0 immediately; captures in flight SHALL be discarded.
REQ-028 SHALL ignore sof_strb in the first cycle after rst_n deasserts only when that strobe coincides with the deassertion edge; capture SHALL proceed normally afterwards.

Configuration
REQ-029 SHALL, when macro PTP_TS_LATCOMP_EN is defined, apply the LAT_NS addition and carry described in REQ-017.
REQ-030 SHALL, when PTP_TS_LATCOMP_EN is undefined, pass S2 through unchanged and ignore LAT_NS, with the 2-cycle latency unchanged.

Structure
REQ-031 SHALL place NS_PER_SEC (10^9), SEC_W=48, NS_W=32, TAG_W=8 and a packed timestamp record {sec, ns, tag} in shared package ptp_ts_pkg.
REQ-032 SHALL implement storage in one sub-module, ptp_ts_fifo, a synchronous FWFT FIFO parameterised by depth and record width.

Verification
REQ-033 With LAT_NS=0 and a single strobe at sec=5, ns=100, tag=3, the bench SHALL see ts_valid 2 cycles later with {5, 100, 3}.
REQ-034 With LAT_NS=16 and a strobe at sec=0xFFFF_FFFF_FFFF, ns=999_999_990, the bench SHALL see output {0, 6} (both carry and wrap).
REQ-035 With 20 back-to-back strobes, ts_ready=0 and FIFO_DEPTH=16, the bench SHALL see 16 entries kept in order, entries 17..20 dropped, overflow=1 and ts_count=16.
REQ-036 With the FIFO full, ts_ready=1 and a continuous strobe stream, the bench SHALL see count stay 16, no overflow and FIFO order preserved.
REQ-037 Asserting rst_n=0 with 5 entries queued and one capture in S2 SHALL clear all outputs at once, and nothing SHALL emerge after release.
REQ-038 With PTP_TS_LATCOMP_EN undefined and LAT_NS=16, a strobe at ns=999_999_990 SHALL yield ns=999_999_990 with sec unchanged.
